// File: rtl/asff_seq.sv
// Command-driven sequencer for a 4-bit preset register: drives load/preset, waits, checks readback.
// Optional feature: define ASFF_SEQ_RETRY_EN to retry a mismatching check once (adds rsp_retried).
module asff_seq #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_data,
    output logic       ff_reset,
    output logic       ff_set,
    output logic [3:0] ff_cs,
    input  logic [3:0] ff_ns,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_ok,
    output logic [3:0] rsp_ns,
    output logic [7:0] err_cnt
`ifdef ASFF_SEQ_RETRY_EN
    ,
    output logic       rsp_retried
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DRIVE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    localparam logic [1:0] OP_LOAD       = 2'b00;
    localparam logic [1:0] OP_PRESET_RST = 2'b01;
    localparam logic [1:0] OP_PRESET_SET = 2'b10;
    localparam logic [1:0] OP_HOLD       = 2'b11;

    localparam logic [3:0] RST_VALUE   = 4'b1101;
    localparam logic [3:0] SET_VALUE   = 4'b0110;
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0] ERR_MAX     = 8'hFF;

    logic [2:0] state_q, state_d;
    logic [1:0] op_q, op_d;
    logic [3:0] exp_q, exp_d;
    logic [3:0] wait_q, wait_d;
    logic       rdy_q, rdy_d;
    logic       ok_q, ok_d;
    logic [3:0] ns_q, ns_d;
    logic [7:0] err_q, err_d;
`ifdef ASFF_SEQ_RETRY_EN
    logic       retried_q, retried_d;
`endif

    logic accept;
    logic mismatch;

    assign accept   = cmd_valid && rdy_q;
    assign mismatch = (ff_ns != exp_q);

    always_comb begin
        // NOTE: every variable gets its hold value first so no path infers a latch.
        state_d = state_q;
        op_d    = op_q;
        exp_d   = exp_q;
        wait_d  = wait_q;
        ok_d    = ok_q;
        ns_d    = ns_q;
        err_d   = err_q;
`ifdef ASFF_SEQ_RETRY_EN
        retried_d = retried_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_DRIVE;
                    op_d    = cmd_op;
`ifdef ASFF_SEQ_RETRY_EN
                    retried_d = 1'b0;
`endif
                    case (cmd_op)
                        OP_LOAD:       exp_d = cmd_data;
                        OP_PRESET_RST: exp_d = RST_VALUE;
                        OP_PRESET_SET: exp_d = SET_VALUE;
                        OP_HOLD:       exp_d = exp_q;
                        default:       exp_d = exp_q;
                    endcase
                end
            end

            S_DRIVE: begin
                state_d = S_WAIT;
                wait_d  = 4'd0;
            end

            S_WAIT: begin
                if (wait_q == SETTLE_LAST) begin
                    state_d = S_CHECK;
                    wait_d  = 4'd0;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end

            S_CHECK: begin
                ns_d = ff_ns;
                ok_d = !mismatch;
`ifdef ASFF_SEQ_RETRY_EN
                if (mismatch && !retried_q) begin
                    // First failure replays the same drive; only the second sample is final.
                    state_d   = S_DRIVE;
                    retried_d = 1'b1;
                end else begin
                    state_d = S_RESP;
                    if (mismatch && (err_q != ERR_MAX)) err_d = err_q + 8'd1;
                end
`else
                state_d = S_RESP;
                if (mismatch && (err_q != ERR_MAX)) err_d = err_q + 8'd1;
`endif
            end

            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Registered so it stays low throughout reset and rises on the first edge after release.
    assign rdy_d = (state_d == S_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_LOAD;
            exp_q   <= 4'b0000;
            wait_q  <= 4'd0;
            rdy_q   <= 1'b0;
            ok_q    <= 1'b0;
            ns_q    <= 4'b0000;
            err_q   <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            op_q    <= op_d;
            exp_q   <= exp_d;
            wait_q  <= wait_d;
            rdy_q   <= rdy_d;
            ok_q    <= ok_d;
            ns_q    <= ns_d;
            err_q   <= err_d;
        end
    end

`ifdef ASFF_SEQ_RETRY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) retried_q <= 1'b0;
        else          retried_q <= retried_d;
    end

    assign rsp_retried = retried_q;
`endif

    // Pulses exist only in DRIVE and decode a single op, so both can never be high together.
    assign ff_reset  = (state_q == S_DRIVE) && (op_q == OP_PRESET_RST);
    assign ff_set    = (state_q == S_DRIVE) && (op_q == OP_PRESET_SET);
    assign ff_cs     = exp_q;
    assign cmd_ready = rdy_q;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_ok    = ok_q;
    assign rsp_ns    = ns_q;
    assign err_cnt   = err_q;

endmodule

// File: tb/tb_asff_seq.sv
// Directed self-checking bench for asff_seq with a looped-back preset register model.
// Define ASFF_SEQ_RETRY_EN for both files to exercise the retry build.
module tb_asff_seq;

    localparam int SETTLE = 1;
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_RST  = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b10;
    localparam logic [1:0] OP_HOLD = 2'b11;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic       ff_reset;
    logic       ff_set;
    logic [3:0] ff_cs;
    logic [3:0] ff_ns;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_ok;
    logic [3:0] rsp_ns;
    logic [7:0] err_cnt;
`ifdef ASFF_SEQ_RETRY_EN
    logic       rsp_retried;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] model_q = 4'b0000;
    logic       force_zero;
    int n_rst_pulse = 0;
    int n_set_pulse = 0;
    int n_both      = 0;

    always #5 clk = ~clk;

    asff_seq #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .ff_reset  (ff_reset),
        .ff_set    (ff_set),
        .ff_cs     (ff_cs),
        .ff_ns     (ff_ns),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_ok    (rsp_ok),
        .rsp_ns    (rsp_ns),
        .err_cnt   (err_cnt)
`ifdef ASFF_SEQ_RETRY_EN
        ,
        .rsp_retried (rsp_retried)
`endif
    );

    // Preset register model: reset/set presets win over the cs load.
    always @(posedge clk) begin
        if (ff_reset)    model_q <= 4'b1101;
        else if (ff_set) model_q <= 4'b0110;
        else             model_q <= ff_cs;
    end

    assign ff_ns = force_zero ? 4'b0000 : model_q;

    always @(posedge clk) begin
        if (ff_reset)           n_rst_pulse <= n_rst_pulse + 1;
        if (ff_set)             n_set_pulse <= n_set_pulse + 1;
        if (ff_reset && ff_set) n_both      <= n_both + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Presents a command, waits for acceptance, then counts edges until rsp_valid.
    task automatic send(input logic [1:0] op, input logic [3:0] data, output int lat);
        int waited;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        waited = 0;
        while (!cmd_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) check("accept_timeout", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!rsp_valid) check("rsp_timeout", rsp_valid, 1);
    endtask

    task automatic respond();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("rsp_drop", rsp_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int r0;
        int s0;

        reset_n    = 1'b0;
        cmd_valid  = 1'b0;
        cmd_op     = OP_LOAD;
        cmd_data   = 4'b0000;
        rsp_ready  = 1'b0;
        force_zero = 1'b0;

        #3;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_ff_cs", ff_cs, 4'b0000);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_pulses", {ff_reset, ff_set}, 2'b00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("release_ready_low", cmd_ready, 0);
        @(posedge clk);
        #1;
        check("release_ready_high", cmd_ready, 1);

        // LOAD 1010 with exact latency.
        send(OP_LOAD, 4'b1010, lat);
        check("load_latency", lat, SETTLE + 2);
        check("load_ff_cs", ff_cs, 4'b1010);
        check("load_ok", rsp_ok, 1);
        check("load_ns", rsp_ns, 4'b1010);
        respond();

        // PRESET_RST then PRESET_SET; cmd_data must be ignored.
        r0 = n_rst_pulse;
        s0 = n_set_pulse;
        send(OP_RST, 4'b0011, lat);
        check("rst_pulse_cnt", n_rst_pulse - r0, 1);
        check("rst_no_set", n_set_pulse - s0, 0);
        check("rst_ns", rsp_ns, 4'b1101);
        check("rst_ok", rsp_ok, 1);
        check("rst_ff_cs", ff_cs, 4'b1101);
        respond();
        r0 = n_rst_pulse;
        s0 = n_set_pulse;
        send(OP_SET, 4'b1111, lat);
        check("set_pulse_cnt", n_set_pulse - s0, 1);
        check("set_no_rst", n_rst_pulse - r0, 0);
        check("set_ns", rsp_ns, 4'b0110);
        check("set_ok", rsp_ok, 1);
        check("set_ff_cs", ff_cs, 4'b0110);
        respond();
        check("never_both", n_both, 0);

        // HOLD after LOAD 0011.
        send(OP_LOAD, 4'b0011, lat);
        respond();
        r0 = n_rst_pulse;
        s0 = n_set_pulse;
        send(OP_HOLD, 4'b1100, lat);
        check("hold_pulses", (n_rst_pulse - r0) + (n_set_pulse - s0), 0);
        check("hold_ff_cs", ff_cs, 4'b0011);
        check("hold_ok", rsp_ok, 1);
        check("hold_ns", rsp_ns, 4'b0011);
        respond();

        // Forced mismatch and saturation of err_cnt.
        force_zero = 1'b1;
        send(OP_LOAD, 4'b1111, lat);
        check("mis_ok", rsp_ok, 0);
        check("mis_ns", rsp_ns, 4'b0000);
        check("mis_err1", err_cnt, 1);
`ifdef ASFF_SEQ_RETRY_EN
        check("mis_retried", rsp_retried, 1);
        check("mis_retry_latency", lat, 2 * (SETTLE + 2));
`else
        check("mis_latency", lat, SETTLE + 2);
`endif
        respond();
        for (int k = 2; k <= 300; k++) begin
            send(OP_LOAD, 4'b1111, lat);
            if (k == 254) check("mis_err254", err_cnt, 254);
            respond();
        end
        check("mis_err_sat", err_cnt, 255);
        force_zero = 1'b0;

        // Back-pressure: response held, new command waits for the handshake.
        send(OP_LOAD, 4'b0101, lat);
        cmd_valid = 1'b1;
        cmd_op    = OP_LOAD;
        cmd_data  = 4'b1001;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("bp_valid", rsp_valid, 1);
            check("bp_ns", rsp_ns, 4'b0101);
            check("bp_ok", rsp_ok, 1);
            check("bp_ready", cmd_ready, 0);
            check("bp_ff_cs", ff_cs, 4'b0101);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("bp_drop", rsp_valid, 0);
        check("bp_ready_back", cmd_ready, 1);
        check("bp_not_yet", ff_cs, 4'b0101);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("bp_accepted", cmd_ready, 0);
        check("bp_new_cs", ff_cs, 4'b1001);
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("bp_new_ok", rsp_ok, 1);
        check("bp_new_ns", rsp_ns, 4'b1001);
        respond();

        // Reset pulsed during WAIT.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_LOAD;
        cmd_data  = 4'b1100;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("mid_cs", ff_cs, 4'b1100);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_ready", cmd_ready, 0);
        check("mid_pulses", {ff_reset, ff_set}, 2'b00);
        check("mid_ff_cs", ff_cs, 4'b0000);
        check("mid_valid", rsp_valid, 0);
        check("mid_ok", rsp_ok, 0);
        check("mid_ns", rsp_ns, 4'b0000);
        check("mid_err", err_cnt, 0);
        @(posedge clk);
        #1;
        check("mid_hold_ready", cmd_ready, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            check("mid_no_rsp", rsp_valid, 0);
        end
        check("mid_ready_back", cmd_ready, 1);
        send(OP_LOAD, 4'b0111, lat);
        check("post_latency", lat, SETTLE + 2);
        check("post_ok", rsp_ok, 1);
        check("post_ns", rsp_ns, 4'b0111);
        check("post_err", err_cnt, 0);
        respond();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
